// File: rtl/fetch_queue.sv
// Instruction prefetch queue: generates sequential fetch PCs, buffers {instr, pc}
// pairs from imem and hands the oldest one to the decoder via valid/ready.
module fetch_queue #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  output logic [WIDTH-1:0]           imem_addr,
  input  logic [WIDTH-1:0]           imem_rd,
  input  logic                       redirect,
  input  logic [WIDTH-1:0]           redirect_pc,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [WIDTH-1:0]           dec_instr,
  output logic [WIDTH-1:0]           dec_pc,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] instr_q [DEPTH];
  logic [WIDTH-1:0] epc_q   [DEPTH];

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic             pop_c;
  logic             push_c;

  assign pop_c  = valid_q & dec_ready;
  assign push_c = fetch_en & ~redirect & (~full_q | pop_c);

  // Next-state: redirect flushes everything and retargets the fetch PC.
  always_comb begin
    pc_d  = pc_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (redirect) begin
      pc_d  = redirect_pc;
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_c) begin
        wr_d = wr_q + PTR_W'(1);
        pc_d = pc_q + WIDTH'(4);
      end
      if (pop_c) begin
        rd_d = rd_q + PTR_W'(1);
      end
      cnt_d = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
    valid_d = (cnt_d != '0);
    full_d  = (cnt_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_PC;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      full_q  <= full_d;
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (push_c) begin
      instr_q[wr_q] <= imem_rd;
      epc_q[wr_q]   <= pc_q;
    end
  end

  assign imem_addr = pc_q;
  assign dec_valid = valid_q;
  assign dec_instr = valid_q ? instr_q[rd_q] : '0;
  assign dec_pc    = valid_q ? epc_q[rd_q] : '0;
  assign count     = cnt_q;
  assign full      = full_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed-vector bench for fetch_queue; imem returns 0xE000_0000 + address.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [2:0]  count;
  logic        full;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_rd = 32'hE000_0000 + imem_addr;

  fetch_queue #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_rd(imem_rd), .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .count(count), .full(full)
  );

  typedef struct {
    logic        rst_n;
    logic        fen;
    logic        rdir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [2:0]  e_cnt;
    logic        e_full;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic fen, input logic rdir,
                     input logic [31:0] rpc, input logic rdy,
                     input logic e_valid, input logic [31:0] e_pc,
                     input logic [2:0] e_cnt, input logic e_full,
                     input logic [31:0] e_addr);
    vec_t v;
    v.rst_n = rst_n; v.fen = fen; v.rdir = rdir; v.rpc = rpc; v.rdy = rdy;
    v.e_valid = e_valid; v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_full = e_full;
    v.e_addr = e_addr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Occupancy must never exceed the queue depth.
  always @(negedge clk) begin
    if (reset === 1'b1 && count > 3'd4) begin
      n_err++;
      $display("FAIL count_bound: got %0d, expected <= 4", count);
    end
  end

  initial begin
    logic [31:0] exp_instr;

    //   rst fen rdir rpc            rdy  valid pc            cnt full addr
    add(0, 0, 0, 32'h0,          0,   0, 32'h0,          0, 0, 32'h0);
    add(0, 0, 0, 32'h0,          0,   0, 32'h0,          0, 0, 32'h0);
    // free run: one word in flight, head advances by 4 each cycle
    add(1, 1, 0, 32'h0,          1,   1, 32'h0,          1, 0, 32'h4);
    add(1, 1, 0, 32'h0,          1,   1, 32'h4,          1, 0, 32'h8);
    add(1, 1, 0, 32'h0,          1,   1, 32'h8,          1, 0, 32'hC);
    // stall from first fetch until full
    add(0, 1, 0, 32'h0,          1,   0, 32'h0,          0, 0, 32'h0);
    add(1, 1, 0, 32'h0,          0,   1, 32'h0,          1, 0, 32'h4);
    add(1, 1, 0, 32'h0,          0,   1, 32'h0,          2, 0, 32'h8);
    add(1, 1, 0, 32'h0,          0,   1, 32'h0,          3, 0, 32'hC);
    add(1, 1, 0, 32'h0,          0,   1, 32'h0,          4, 1, 32'h10);
    add(1, 1, 0, 32'h0,          0,   1, 32'h0,          4, 1, 32'h10);
    // full with simultaneous push/pop
    add(1, 1, 0, 32'h0,          1,   1, 32'h4,          4, 1, 32'h14);
    // drain in order with fetch disabled
    add(1, 0, 0, 32'h0,          1,   1, 32'h8,          3, 0, 32'h14);
    add(1, 0, 0, 32'h0,          1,   1, 32'hC,          2, 0, 32'h14);
    add(1, 0, 0, 32'h0,          1,   1, 32'h10,         1, 0, 32'h14);
    add(1, 0, 0, 32'h0,          1,   0, 32'h0,          0, 0, 32'h14);
    // resume fetching, queue 3 entries, then redirect mid-stream
    add(1, 1, 0, 32'h0,          0,   1, 32'h14,         1, 0, 32'h18);
    add(1, 1, 0, 32'h0,          0,   1, 32'h14,         2, 0, 32'h1C);
    add(1, 1, 0, 32'h0,          0,   1, 32'h14,         3, 0, 32'h20);
    add(1, 1, 1, 32'h100,        1,   0, 32'h0,          0, 0, 32'h100);
    add(1, 1, 0, 32'h0,          1,   1, 32'h100,        1, 0, 32'h104);
    add(1, 1, 0, 32'h0,          1,   1, 32'h104,        1, 0, 32'h108);
    // reset overrides redirect
    add(0, 1, 1, 32'h200,        1,   0, 32'h0,          0, 0, 32'h0);
    // two entries then drain with fetch_en=0; pc holds
    add(1, 1, 0, 32'h0,          0,   1, 32'h0,          1, 0, 32'h4);
    add(1, 1, 0, 32'h0,          0,   1, 32'h0,          2, 0, 32'h8);
    add(1, 0, 0, 32'h0,          1,   1, 32'h4,          1, 0, 32'h8);
    add(1, 0, 0, 32'h0,          1,   0, 32'h0,          0, 0, 32'h8);
    add(1, 0, 0, 32'h0,          1,   0, 32'h0,          0, 0, 32'h8);
    // PC wrap at the top of the address space
    add(1, 1, 1, 32'hFFFF_FFFC,  0,   0, 32'h0,          0, 0, 32'hFFFF_FFFC);
    add(1, 1, 0, 32'h0,          0,   1, 32'hFFFF_FFFC,  1, 0, 32'h0);
    add(1, 1, 0, 32'h0,          0,   1, 32'hFFFF_FFFC,  2, 0, 32'h4);
    add(1, 0, 0, 32'h0,          1,   1, 32'h0,          1, 0, 32'h4);
    add(1, 0, 0, 32'h0,          1,   0, 32'h0,          0, 0, 32'h4);

    reset = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;

    foreach (vecs[i]) begin
      reset       = vecs[i].rst_n;
      fetch_en    = vecs[i].fen;
      redirect    = vecs[i].rdir;
      redirect_pc = vecs[i].rpc;
      dec_ready   = vecs[i].rdy;
      @(posedge clk);
      #1;
      exp_instr = vecs[i].e_valid ? 32'hE000_0000 + vecs[i].e_pc : 32'h0;
      check($sformatf("v%0d.dec_valid", i), 32'(dec_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d.dec_pc", i),    dec_pc,         vecs[i].e_pc);
      check($sformatf("v%0d.dec_instr", i), dec_instr,      exp_instr);
      check($sformatf("v%0d.count", i),     32'(count),     32'(vecs[i].e_cnt));
      check($sformatf("v%0d.full", i),      32'(full),      32'(vecs[i].e_full));
      check($sformatf("v%0d.imem_addr", i), imem_addr,      vecs[i].e_addr);
    end

    // Redirect while popping a queue of stale words: only new-stream PCs may appear.
    fetch_en = 1'b1; dec_ready = 1'b0; redirect = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    check("hs.prefill_count", 32'(count), 32'd3);
    redirect = 1'b1; redirect_pc = 32'h300; dec_ready = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b0;
    check("hs.flush_valid", 32'(dec_valid), 32'd0);
    check("hs.flush_addr", imem_addr, 32'h300);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check($sformatf("hs.valid%0d", c), 32'(dec_valid), 32'd1);
      check($sformatf("hs.pc%0d", c), dec_pc, 32'h300 + 32'(4 * c));
      check($sformatf("hs.instr%0d", c), dec_instr, 32'hE000_0300 + 32'(4 * c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
